// File: rtl/bitcoin_mem_responder.sv
// Word memory and run sequencer serving the bitcoin_hash engine's memory bus.
// Define BEST_TRACK_EN to track the minimum result hash and its nonce.
module bitcoin_mem_responder #(
  parameter int          DEPTH      = 64,
  parameter logic [15:0] OUT_BASE   = 16'h0020,
  parameter int          NUM_NONCES = 16,
  parameter int          TIMEOUT    = 8192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  input  logic        run,
  output logic        busy,
  output logic        complete,
  output logic        timeout_err,
  output logic        count_err,
  output logic        addr_err,
  output logic [7:0]  result_count,
  output logic [31:0] best_hash,
  output logic [7:0]  best_nonce,
  output logic        core_start,
  input  logic        core_done,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data
);
  localparam int          AW       = $clog2(DEPTH);
  localparam int          WW       = $clog2(TIMEOUT) + 1;
  localparam logic [15:0] DEPTH_W  = 16'(DEPTH);
  localparam logic [15:0] WIN_END  = 16'(int'(OUT_BASE) + NUM_NONCES);
  localparam logic [7:0]  NONCES_W = 8'(NUM_NONCES);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t        state_reg;
  logic [31:0]   mem [DEPTH];
  logic [WW-1:0] wd_reg;
  logic [31:0]   host_rdata_reg, mem_read_data_reg;
  logic [7:0]    result_count_reg, count_next;
  logic          core_start_reg, complete_reg, timeout_err_reg, count_err_reg, addr_err_reg;
  logic          host_in, eng_in, ready, host_wr, eng_wr, in_window;

  always_comb begin
    host_in   = host_addr < DEPTH_W;
    eng_in    = mem_addr < DEPTH_W;
    ready     = (state_reg == IDLE) || (state_reg == DONE);
    // reset gates both write ports so a run aborted by reset captures nothing more
    host_wr   = !reset && ready && host_we && host_in;
    eng_wr    = !reset && (state_reg == WAIT) && mem_we && eng_in;
    in_window = eng_wr && (mem_addr >= OUT_BASE) && (mem_addr < WIN_END);
    count_next = result_count_reg;
    if (in_window && result_count_reg != 8'hFF)
      count_next = result_count_reg + 8'd1;
  end

  // Host and engine writes are never enabled in the same state, so one write port suffices.
  always_ff @(posedge clk) begin
    if (host_wr)
      mem[host_addr[AW-1:0]] <= host_wdata;
    else if (eng_wr)
      mem[mem_addr[AW-1:0]] <= mem_write_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      host_rdata_reg    <= '0;
      mem_read_data_reg <= '0;
    end else begin
      host_rdata_reg    <= host_in ? mem[host_addr[AW-1:0]] : 32'h0;
      mem_read_data_reg <= eng_in ? mem[mem_addr[AW-1:0]] : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      core_start_reg   <= 1'b0;
      complete_reg     <= 1'b0;
      timeout_err_reg  <= 1'b0;
      count_err_reg    <= 1'b0;
      addr_err_reg     <= 1'b0;
      result_count_reg <= '0;
      wd_reg           <= '0;
    end else begin
      if (!host_in || !eng_in)
        addr_err_reg <= 1'b1;
      case (state_reg)
        IDLE, DONE: begin
          if (run) begin
            state_reg        <= START;
            core_start_reg   <= 1'b1;
            result_count_reg <= '0;
            timeout_err_reg  <= 1'b0;
            count_err_reg    <= 1'b0;
            complete_reg     <= 1'b0;
          end
        end
        START: begin
          core_start_reg <= 1'b0;
          wd_reg         <= '0;
          state_reg      <= WAIT;
        end
        WAIT: begin
          // count_next folds in a write landing in the same cycle as core_done
          result_count_reg <= count_next;
          if (core_done) begin
            state_reg     <= DONE;
            complete_reg  <= 1'b1;
            count_err_reg <= (count_next != NONCES_W);
          end else if (wd_reg == WD_LAST) begin
            state_reg       <= DONE;
            complete_reg    <= 1'b1;
            timeout_err_reg <= 1'b1;
          end else begin
            wd_reg <= wd_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef BEST_TRACK_EN
  logic [31:0] best_hash_reg;
  logic [7:0]  best_nonce_reg;
  logic [15:0] offset;

  assign offset = mem_addr - OUT_BASE;

  always_ff @(posedge clk) begin
    if (reset) begin
      best_hash_reg  <= 32'hFFFF_FFFF;
      best_nonce_reg <= '0;
    end else if (ready && run) begin
      best_hash_reg  <= 32'hFFFF_FFFF;
      best_nonce_reg <= '0;
    end else if (in_window && (mem_write_data < best_hash_reg)) begin
      // strict compare keeps the earlier write on ties
      best_hash_reg  <= mem_write_data;
      best_nonce_reg <= offset[7:0];
    end
  end

  assign best_hash  = best_hash_reg;
  assign best_nonce = best_nonce_reg;
`else
  assign best_hash  = '0;
  assign best_nonce = '0;
`endif

  assign host_rdata    = host_rdata_reg;
  assign mem_read_data = mem_read_data_reg;
  assign busy          = (state_reg == START) || (state_reg == WAIT);
  assign complete      = complete_reg;
  assign timeout_err   = timeout_err_reg;
  assign count_err     = count_err_reg;
  assign addr_err      = addr_err_reg;
  assign result_count  = result_count_reg;
  assign core_start    = core_start_reg;
endmodule

// File: tb/tb_bitcoin_mem_responder.sv
// Directed bench for bitcoin_mem_responder; expectations follow BEST_TRACK_EN if defined.
module tb_bitcoin_mem_responder;
`ifdef BEST_TRACK_EN
  localparam bit BT = 1'b1;
`else
  localparam bit BT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, host_we, run, core_done, mem_we;
  logic [15:0] host_addr, mem_addr;
  logic [31:0] host_wdata, mem_write_data;
  logic [31:0] host_rdata, mem_read_data, best_hash;
  logic        busy, complete, timeout_err, count_err, addr_err, core_start;
  logic [7:0]  result_count, best_nonce;

  int n_cmp = 0;
  int n_bad = 0;

  bitcoin_mem_responder #(.TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .run(run), .busy(busy), .complete(complete), .timeout_err(timeout_err),
    .count_err(count_err), .addr_err(addr_err), .result_count(result_count),
    .best_hash(best_hash), .best_nonce(best_nonce), .core_start(core_start),
    .core_done(core_done), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bh(input logic [31:0] v);
    return BT ? v : 32'h0;
  endfunction

  function automatic logic [7:0] bn(input logic [7:0] v);
    return BT ? v : 8'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
  endtask

  task automatic engine_writes(input int n);
    for (int k = 0; k < n; k++) begin
      mem_we = 1'b1;
      mem_addr = 16'h0020 + 16'(k);
      mem_write_data = (k == 9) ? 32'h0000_0042 : 32'hF000_0000 - 32'(k);
      tick();
    end
    mem_we = 1'b0;
    mem_addr = 16'h0;
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    $display("reset: busy=%0b complete=%0b best_hash=%h", busy, complete, best_hash);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (core_start !== 1'b0) begin n_bad++; $display("FAIL reset_core_start: got %0b want 0", core_start); end
    n_cmp++; if ({complete, timeout_err, count_err, addr_err} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {complete, timeout_err, count_err, addr_err}); end
    n_cmp++; if (result_count !== 8'h0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", result_count); end
    n_cmp++; if (best_hash !== bh(32'hFFFF_FFFF)) begin n_bad++; $display("FAIL reset_best_hash: got %h want %h", best_hash, bh(32'hFFFF_FFFF)); end
    n_cmp++; if ({host_rdata, mem_read_data} !== 64'h0) begin n_bad++; $display("FAIL reset_rdata: got %h/%h want 0/0", host_rdata, mem_read_data); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_host_load();
    for (int k = 0; k < 20; k++) begin
      host_we = 1'b1;
      host_addr = 16'(k);
      host_wdata = 32'h0123_4567 + 32'(k);
      tick();
      $display("host write: addr=%0d data=%h", k, 32'h0123_4567 + 32'(k));
    end
    host_addr = 16'h0030;
    host_wdata = 32'h5A5A_5A5A;
    tick();
    host_we = 1'b0;
    host_addr = 16'd5;
    mem_addr = 16'd5;
    tick();
    $display("host read: addr=5 host_rdata=%h mem_read_data=%h", host_rdata, mem_read_data);
    n_cmp++; if (host_rdata !== 32'h0123_456C) begin n_bad++; $display("FAIL host_read5: got %h want 0123456c", host_rdata); end
    n_cmp++; if (mem_read_data !== 32'h0123_456C) begin n_bad++; $display("FAIL engine_read5: got %h want 0123456c", mem_read_data); end
    host_addr = 16'd19;
    mem_addr = 16'h0030;
    tick();
    n_cmp++; if (host_rdata !== 32'h0123_457A) begin n_bad++; $display("FAIL host_read19: got %h want 0123457a", host_rdata); end
    n_cmp++; if (mem_read_data !== 32'h5A5A_5A5A) begin n_bad++; $display("FAIL engine_read30: got %h want 5a5a5a5a", mem_read_data); end
    host_addr = 16'h0;
    mem_addr = 16'h0;
  endtask

  task automatic test_run_full();
    run = 1'b1;
    tick();
    run = 1'b0;
    n_cmp++; if ({core_start, busy} !== 2'b11) begin n_bad++; $display("FAIL start_pulse: got start/busy=%b want 11", {core_start, busy}); end
    tick();
    n_cmp++; if ({core_start, busy} !== 2'b01) begin n_bad++; $display("FAIL start_one_cycle: got start/busy=%b want 01", {core_start, busy}); end
    engine_writes(16);
    pulse_done();
    $display("run full: count=%0d count_err=%0b best=%h nonce=%0d", result_count, count_err, best_hash, best_nonce);
    n_cmp++; if ({complete, count_err, timeout_err, busy} !== 4'b1000) begin n_bad++; $display("FAIL full_flags: got %b want 1000", {complete, count_err, timeout_err, busy}); end
    n_cmp++; if (result_count !== 8'd16) begin n_bad++; $display("FAIL full_count: got %0d want 16", result_count); end
    n_cmp++; if (best_hash !== bh(32'h42)) begin n_bad++; $display("FAIL full_best_hash: got %h want %h", best_hash, bh(32'h42)); end
    n_cmp++; if (best_nonce !== bn(8'd9)) begin n_bad++; $display("FAIL full_best_nonce: got %0d want %0d", best_nonce, bn(8'd9)); end
    host_addr = 16'h0029;
    tick();
    n_cmp++; if (host_rdata !== 32'h42) begin n_bad++; $display("FAIL full_mem29: got %h want 00000042", host_rdata); end
    host_addr = 16'h002F;
    tick();
    n_cmp++; if (host_rdata !== 32'hEFFF_FFF1) begin n_bad++; $display("FAIL full_mem2f: got %h want efffff f1", host_rdata); end
    host_addr = 16'h0;
  endtask

  task automatic test_addr_err_and_ties();
    start_run();
    mem_we = 1'b1;
    mem_addr = 16'h0050;
    mem_write_data = 32'h1111_1111;
    tick();
    n_cmp++; if (addr_err !== 1'b1) begin n_bad++; $display("FAIL oob_addr_err: got %0b want 1", addr_err); end
    n_cmp++; if (mem_read_data !== 32'h0) begin n_bad++; $display("FAIL oob_read: got %h want 0", mem_read_data); end
    mem_addr = 16'h0020;
    mem_write_data = 32'hAAAA_0000;
    tick();
    n_cmp++; if (mem_read_data !== 32'hF000_0000) begin n_bad++; $display("FAIL rdw_old: got %h want f0000000", mem_read_data); end
    mem_we = 1'b0;
    tick();
    n_cmp++; if (mem_read_data !== 32'hAAAA_0000) begin n_bad++; $display("FAIL rdw_new: got %h want aaaa0000", mem_read_data); end
    mem_we = 1'b1;
    mem_addr = 16'h0023; mem_write_data = 32'h7; tick();
    mem_addr = 16'h0025; mem_write_data = 32'h7; tick();
    mem_addr = 16'h0026; mem_write_data = 32'h8; tick();
    mem_we = 1'b0;
    mem_addr = 16'h0010;
    tick();
    n_cmp++; if (mem_read_data !== 32'h0123_4577) begin n_bad++; $display("FAIL oob_no_alias: got %h want 01234577", mem_read_data); end
    mem_addr = 16'h0;
    pulse_done();
    $display("run ties: count=%0d count_err=%0b best=%h nonce=%0d", result_count, count_err, best_hash, best_nonce);
    n_cmp++; if (result_count !== 8'd4) begin n_bad++; $display("FAIL ties_count: got %0d want 4", result_count); end
    n_cmp++; if (count_err !== 1'b1) begin n_bad++; $display("FAIL ties_count_err: got %0b want 1", count_err); end
    n_cmp++; if (best_hash !== bh(32'h7)) begin n_bad++; $display("FAIL ties_best_hash: got %h want %h", best_hash, bh(32'h7)); end
    n_cmp++; if (best_nonce !== bn(8'd3)) begin n_bad++; $display("FAIL ties_best_nonce: got %0d want %0d", best_nonce, bn(8'd3)); end
  endtask

  task automatic test_short_run();
    run = 1'b1;
    tick();
    run = 1'b0;
    n_cmp++; if ({complete, count_err, result_count} !== 10'b0) begin n_bad++; $display("FAIL short_clear: got complete=%0b count_err=%0b count=%0d want 0", complete, count_err, result_count); end
    n_cmp++; if (best_hash !== bh(32'hFFFF_FFFF)) begin n_bad++; $display("FAIL short_best_clear: got %h want %h", best_hash, bh(32'hFFFF_FFFF)); end
    tick();
    engine_writes(15);
    pulse_done();
    $display("run short: count=%0d count_err=%0b complete=%0b", result_count, count_err, complete);
    n_cmp++; if ({complete, count_err} !== 2'b11) begin n_bad++; $display("FAIL short_flags: got %b want 11", {complete, count_err}); end
    n_cmp++; if (result_count !== 8'd15) begin n_bad++; $display("FAIL short_count: got %0d want 15", result_count); end
  endtask

  task automatic test_write_with_done();
    start_run();
    engine_writes(15);
    mem_we = 1'b1;
    mem_addr = 16'h002F;
    mem_write_data = 32'h3;
    core_done = 1'b1;
    tick();
    mem_we = 1'b0;
    core_done = 1'b0;
    mem_addr = 16'h0;
    $display("run write+done: count=%0d count_err=%0b best=%h nonce=%0d", result_count, count_err, best_hash, best_nonce);
    n_cmp++; if (result_count !== 8'd16) begin n_bad++; $display("FAIL wd_count: got %0d want 16", result_count); end
    n_cmp++; if ({complete, count_err} !== 2'b10) begin n_bad++; $display("FAIL wd_flags: got %b want 10", {complete, count_err}); end
    n_cmp++; if (best_nonce !== bn(8'd15)) begin n_bad++; $display("FAIL wd_best_nonce: got %0d want %0d", best_nonce, bn(8'd15)); end
  endtask

  task automatic test_timeout();
    start_run();
    for (int i = 0; i < 63; i++) tick();
    n_cmp++; if ({busy, complete} !== 2'b10) begin n_bad++; $display("FAIL to_early: got busy/complete=%b want 10", {busy, complete}); end
    tick();
    $display("run timeout: timeout_err=%0b complete=%0b busy=%0b", timeout_err, complete, busy);
    n_cmp++; if ({timeout_err, complete, busy, count_err} !== 4'b1100) begin n_bad++; $display("FAIL to_flags: got %b want 1100", {timeout_err, complete, busy, count_err}); end
    mem_we = 1'b1;
    mem_addr = 16'h0030;
    mem_write_data = 32'hDEAD_BEEF;
    core_done = 1'b1;
    tick();
    mem_we = 1'b0;
    core_done = 1'b0;
    host_addr = 16'h0030;
    tick();
    n_cmp++; if (host_rdata !== 32'h5A5A_5A5A) begin n_bad++; $display("FAIL to_write_ignored: got %h want 5a5a5a5a", host_rdata); end
    n_cmp++; if ({count_err, result_count} !== 9'b0) begin n_bad++; $display("FAIL to_done_ignored: got count_err=%0b count=%0d want 0", count_err, result_count); end
    host_addr = 16'h0;
    mem_addr = 16'h0;
  endtask

  task automatic test_reset_mid_run();
    start_run();
    mem_we = 1'b1;
    mem_addr = 16'h0020; mem_write_data = 32'h1; tick();
    mem_addr = 16'h0021; mem_write_data = 32'h2; tick();
    mem_addr = 16'h0022; mem_write_data = 32'hBBBB_BBBB;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_we = 1'b0;
    $display("reset mid-run: busy=%0b count=%0d addr_err=%0b", busy, result_count, addr_err);
    n_cmp++; if ({busy, core_start, complete, addr_err} !== 4'b0) begin n_bad++; $display("FAIL mid_flags: got %b want 0000", {busy, core_start, complete, addr_err}); end
    n_cmp++; if (result_count !== 8'h0) begin n_bad++; $display("FAIL mid_count: got %0d want 0", result_count); end
    n_cmp++; if (best_hash !== bh(32'hFFFF_FFFF)) begin n_bad++; $display("FAIL mid_best_hash: got %h want %h", best_hash, bh(32'hFFFF_FFFF)); end
    host_addr = 16'h0022;
    tick();
    n_cmp++; if (host_rdata !== 32'hEFFF_FFFE) begin n_bad++; $display("FAIL mid_write_dropped: got %h want effffffe", host_rdata); end
    host_addr = 16'h0021;
    tick();
    n_cmp++; if (host_rdata !== 32'h2) begin n_bad++; $display("FAIL mid_write_kept: got %h want 00000002", host_rdata); end
    host_addr = 16'h0;
    start_run();
    engine_writes(16);
    pulse_done();
    $display("run after reset: count=%0d count_err=%0b best=%h nonce=%0d", result_count, count_err, best_hash, best_nonce);
    n_cmp++; if ({complete, count_err, timeout_err} !== 3'b100) begin n_bad++; $display("FAIL post_flags: got %b want 100", {complete, count_err, timeout_err}); end
    n_cmp++; if (result_count !== 8'd16) begin n_bad++; $display("FAIL post_count: got %0d want 16", result_count); end
    n_cmp++; if (best_nonce !== bn(8'd9)) begin n_bad++; $display("FAIL post_best_nonce: got %0d want %0d", best_nonce, bn(8'd9)); end
  endtask

  initial begin
    reset = 1'b1;
    host_we = 1'b0; host_addr = 16'h0; host_wdata = 32'h0;
    run = 1'b0; core_done = 1'b0;
    mem_we = 1'b0; mem_addr = 16'h0; mem_write_data = 32'h0;
    test_reset();
    test_host_load();
    test_run_full();
    test_addr_err_and_ties();
    test_short_run();
    test_write_with_done();
    test_timeout();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
